pipelined_decode_stage: RTL and testbench

- Second-generation RV64 decode stage.
- Generalises the combinational decoder: parametrised XLEN and register count, internal 2R1W register file with write-through bypass, full I/S/B immediate generation, and an ID/EX output register with valid/ready handshakes.
- Also adds load-use stall insertion, flush, and illegal-instruction flagging.
- Sits between fetch (IF/ID) and execute.

---
 rtl/decode_pkg.sv | 41 ++++
 rtl/decode_regfile.sv | 45 ++++
 rtl/pipelined_decode_stage.sv | 180 ++++++++++++++++++
 tb/tb_pipelined_decode_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode constants, control bundle and operand-usage helper for pipelined_decode_stage.
// Shift encodings exist only when DECODE_SHIFT_EN is defined.
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
`ifdef DECODE_SHIFT_EN
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b0101;
`endif

  typedef struct packed {
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       illegal;
    logic [3:0] alu_ctrl;
  } ctrl_t;

  // Only these formats read rs2; the load-use check ignores rs2 otherwise.
  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// 2R1W architectural register file with write-through bypass and hardwired x0.
module decode_regfile
  import decode_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] rs2_val,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [AW-1:0]   ra1, ra2, wa;
  logic [XLEN-1:0] regs [NREGS];

  assign ra1 = rs1_addr[AW-1:0];
  assign ra2 = rs2_addr[AW-1:0];
  assign wa  = wb_addr[AW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en && (wa != '0)) begin
      regs[wa] <= wb_data;
    end
  end

  always_comb begin
    rs1_val = regs[ra1];
    if (ra1 == '0)                    rs1_val = '0;
    else if (wb_en && (wa == ra1))    rs1_val = wb_data;
    rs2_val = regs[ra2];
    if (ra2 == '0)                    rs2_val = '0;
    else if (wb_en && (wa == ra2))    rs2_val = wb_data;
  end

endmodule

// File: rtl/pipelined_decode_stage.sv
// RV64 decode stage: register read, immediate/control decode, load-use stall, ID/EX register.
// Define DECODE_SHIFT_EN to decode SLL/SRL/SRA and their immediate forms.
module pipelined_decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [3:0]      out_alu_ctrl,
  output logic            out_alu_src,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_mem_to_reg,
  output logic            out_branch,
  output logic            out_illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rs1_p0, rs2_p0, rd_p0;
  logic [XLEN-1:0] rs1_val_p0, rs2_val_p0;
  logic signed [XLEN-1:0] imm_i, imm_s, imm_b, imm_p0;
`ifdef DECODE_SHIFT_EN
  logic signed [XLEN-1:0] imm_sh;
  logic                   shamt_ok;
`endif
  ctrl_t      ctrl_p0;
  logic [1:0] aluop;
  logic [3:0] alu_code;
  logic       alu_ok;
  logic       is_imm;
  logic       adv, haz;

  logic                   vld_p1;
  logic [XLEN-1:0]        pc_p1, rs1_val_p1, rs2_val_p1;
  logic signed [XLEN-1:0] imm_p1;
  logic [4:0]             rs1_p1, rs2_p1, rd_p1;
  ctrl_t                  ctrl_p1;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign rs1_p0 = in_instr[19:15];
  assign rs2_p0 = in_instr[24:20];
  assign rd_p0  = in_instr[11:7];
  assign is_imm = (opcode == OP_IMM);

  assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0};
`ifdef DECODE_SHIFT_EN
  assign imm_sh   = {{(XLEN-6){1'b0}}, in_instr[25:20]};
  assign shamt_ok = !is_imm || (in_instr[31:26] == 6'b000000) || (in_instr[31:26] == 6'b010000);
`endif

  decode_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rs1_addr (rs1_p0),
    .rs2_addr (rs2_p0),
    .rs1_val  (rs1_val_p0),
    .rs2_val  (rs2_val_p0),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data)
  );

  always_comb begin
    ctrl_p0  = '0;
    imm_p0   = '0;
    aluop    = ALUOP_ADD;
    alu_code = ALU_ADD;
    alu_ok   = 1'b1;
    case (opcode)
      OP_R:      begin ctrl_p0.reg_write = 1'b1; aluop = ALUOP_FUNCT; end
      OP_IMM:    begin ctrl_p0.alu_src = 1'b1; ctrl_p0.reg_write = 1'b1;
                       aluop = ALUOP_FUNCT; imm_p0 = imm_i; end
      OP_LOAD:   begin ctrl_p0.alu_src = 1'b1; ctrl_p0.mem_read = 1'b1;
                       ctrl_p0.mem_to_reg = 1'b1; ctrl_p0.reg_write = 1'b1; imm_p0 = imm_i; end
      OP_STORE:  begin ctrl_p0.alu_src = 1'b1; ctrl_p0.mem_write = 1'b1; imm_p0 = imm_s; end
      OP_BRANCH: begin ctrl_p0.branch = 1'b1; aluop = ALUOP_SUB; imm_p0 = imm_b; end
      default:   alu_ok = 1'b0;
    endcase
    // funct7[5] distinguishes SUB only for register-register ADD; ADDI ignores it.
    if (aluop == ALUOP_FUNCT) begin
      case (funct3)
        3'b000:  alu_code = (!is_imm && in_instr[30]) ? ALU_SUB : ALU_ADD;
        3'b111:  alu_code = ALU_AND;
        3'b110:  alu_code = ALU_OR;
`ifdef DECODE_SHIFT_EN
        3'b001:  begin alu_code = ALU_SLL; alu_ok = shamt_ok; if (is_imm) imm_p0 = imm_sh; end
        3'b101:  begin alu_code = in_instr[30] ? ALU_SRA : ALU_SRL;
                       alu_ok = shamt_ok; if (is_imm) imm_p0 = imm_sh; end
`endif
        default: alu_ok = 1'b0;
      endcase
    end else if (aluop == ALUOP_SUB) begin
      alu_code = ALU_SUB;
    end
    if (alu_ok) begin
      ctrl_p0.alu_ctrl = alu_code;
    end else begin
      ctrl_p0         = '0;
      ctrl_p0.illegal = 1'b1;
      imm_p0          = '0;
    end
  end

  assign adv = !vld_p1 || out_ready;
  assign haz = vld_p1 && ctrl_p1.mem_read && (rd_p1 != 5'd0) &&
               ((rd_p1 == rs1_p0) || ((rd_p1 == rs2_p0) && uses_rs2(opcode)));
  assign in_ready = adv && !haz && !flush;

  // ---- ID/EX register (p0 -> p1) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      pc_p1      <= '0;
      rs1_val_p1 <= '0;
      rs2_val_p1 <= '0;
      imm_p1     <= '0;
      rs1_p1     <= '0;
      rs2_p1     <= '0;
      rd_p1      <= '0;
      ctrl_p1    <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (adv && haz) begin
      vld_p1 <= 1'b0;
    end else if (adv) begin
      vld_p1     <= in_valid;
      pc_p1      <= in_pc;
      rs1_val_p1 <= rs1_val_p0;
      rs2_val_p1 <= rs2_val_p0;
      imm_p1     <= imm_p0;
      rs1_p1     <= rs1_p0;
      rs2_p1     <= rs2_p0;
      rd_p1      <= rd_p0;
      ctrl_p1    <= ctrl_p0;
    end
  end

  assign out_valid      = vld_p1;
  assign out_pc         = pc_p1;
  assign out_rs1_val    = rs1_val_p1;
  assign out_rs2_val    = rs2_val_p1;
  assign out_imm        = imm_p1;
  assign out_rs1        = rs1_p1;
  assign out_rs2        = rs2_p1;
  assign out_rd         = rd_p1;
  assign out_alu_ctrl   = ctrl_p1.alu_ctrl;
  assign out_alu_src    = ctrl_p1.alu_src;
  assign out_reg_write  = ctrl_p1.reg_write;
  assign out_mem_read   = ctrl_p1.mem_read;
  assign out_mem_write  = ctrl_p1.mem_write;
  assign out_mem_to_reg = ctrl_p1.mem_to_reg;
  assign out_branch     = ctrl_p1.branch;
  assign out_illegal    = ctrl_p1.illegal;

endmodule

// File: tb/tb_pipelined_decode_stage.sv
// Directed bench for pipelined_decode_stage; shift expectations follow DECODE_SHIFT_EN.
module tb_pipelined_decode_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, wb_en, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc, wb_data;
  logic [4:0]  wb_addr;
  logic        in_ready, out_valid;
  logic [63:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [3:0]  out_alu_ctrl;
  logic        out_alu_src, out_reg_write, out_mem_read, out_mem_write;
  logic        out_mem_to_reg, out_branch, out_illegal;
  logic [10:0] ctrl_obs;

  int checks = 0;
  int errors = 0;

  // src, reg_write, mem_read, mem_write, mem_to_reg, branch, illegal, alu_ctrl
  localparam logic [10:0] C_R      = 11'b0100000_0010;
  localparam logic [10:0] C_ADDI   = 11'b1100000_0010;
  localparam logic [10:0] C_LOAD   = 11'b1110100_0010;
  localparam logic [10:0] C_STORE  = 11'b1001000_0010;
  localparam logic [10:0] C_BRANCH = 11'b0000010_0110;
  localparam logic [10:0] C_ILL    = 11'b0000001_0000;

  assign ctrl_obs = {out_alu_src, out_reg_write, out_mem_read, out_mem_write,
                     out_mem_to_reg, out_branch, out_illegal, out_alu_ctrl};

  pipelined_decode_stage #(.XLEN(64), .NREGS(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_alu_ctrl(out_alu_ctrl), .out_alu_src(out_alu_src), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_mem_to_reg(out_mem_to_reg), .out_branch(out_branch), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [63:0] pc);
    in_instr = instr;
    in_pc    = pc;
    in_valid = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_instr = 32'h0; in_pc = 64'h0;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 64'h777;
    tick(); tick();
    reset = 1'b0; wb_en = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_pc !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", out_pc); end
    checks++; if (out_imm !== 64'h0) begin errors++; $display("FAIL reset_imm: got %h want 0", out_imm); end
    checks++; if (ctrl_obs !== 11'h0) begin errors++; $display("FAIL reset_ctrl: got %b want 0", ctrl_obs); end
    checks++; if ({out_rs1, out_rs2, out_rd} !== 15'h0) begin errors++; $display("FAIL reset_addrs: got %h want 0", {out_rs1, out_rs2, out_rd}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    issue(enc_r(7'h00, 5'd0, 5'd5, 3'b000, 5'd6, 7'b0110011), 64'h40);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL post_reset_valid: got %b want 1", out_valid); end
    checks++; if (out_rs1_val !== 64'h0) begin errors++; $display("FAIL wb_during_reset_ignored: got %h want 0", out_rs1_val); end
    tick();
  endtask

  task automatic test_basic_add();
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 64'h1234;
    tick();
    wb_en = 1'b0;
    issue(enc_r(7'h00, 5'd0, 5'd5, 3'b000, 5'd6, 7'b0110011), 64'h100);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", out_valid); end
    checks++; if (out_rs1_val !== 64'h1234) begin errors++; $display("FAIL add_rs1_val: got %h want 1234", out_rs1_val); end
    checks++; if (ctrl_obs !== C_R) begin errors++; $display("FAIL add_ctrl: got %b want %b", ctrl_obs, C_R); end
    checks++; if (out_rd !== 5'd6) begin errors++; $display("FAIL add_rd: got %0d want 6", out_rd); end
    checks++; if (out_pc !== 64'h100) begin errors++; $display("FAIL add_pc: got %h want 100", out_pc); end
    checks++; if (out_imm !== 64'h0) begin errors++; $display("FAIL add_imm: got %h want 0", out_imm); end
    wb_en = 1'b1; wb_addr = 5'd10; wb_data = 64'hABCD;
    issue(enc_r(7'h00, 5'd10, 5'd10, 3'b000, 5'd11, 7'b0110011), 64'h104);
    tick();
    wb_en = 1'b0; in_valid = 1'b0;
    checks++; if ({out_rs1_val, out_rs2_val} !== {64'hABCD, 64'hABCD}) begin errors++;
      $display("FAIL write_through: got %h/%h want abcd/abcd", out_rs1_val, out_rs2_val); end
    tick();
  endtask

  task automatic test_load_use();
    issue(enc_i(12'd8, 5'd1, 3'b011, 5'd7, 7'b0000011), 64'h200);
    tick();
    checks++; if (ctrl_obs !== C_LOAD) begin errors++; $display("FAIL ld_ctrl: got %b want %b", ctrl_obs, C_LOAD); end
    checks++; if (out_imm !== 64'd8) begin errors++; $display("FAIL ld_imm: got %h want 8", out_imm); end
    issue(enc_r(7'h00, 5'd2, 5'd7, 3'b000, 5'd8, 7'b0110011), 64'h204);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ld_use_in_ready: got %b want 0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ld_use_bubble: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL after_bubble_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if ({out_valid, out_pc} !== {1'b1, 64'h204}) begin errors++;
      $display("FAIL ld_use_add: got valid=%b pc=%h want 1/204", out_valid, out_pc); end
    checks++; if ({out_rs1, out_rd} !== {5'd7, 5'd8}) begin errors++;
      $display("FAIL ld_use_add_regs: got rs1=%0d rd=%0d want 7/8", out_rs1, out_rd); end
    tick();
  endtask

  task automatic test_store_branch();
    issue(enc_s(12'hFFC, 5'd3, 5'd2, 3'b010), 64'h300);
    tick();
    checks++; if (out_imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL sw_imm: got %h want fffffffffffffffc", out_imm); end
    checks++; if (ctrl_obs !== C_STORE) begin errors++; $display("FAIL sw_ctrl: got %b want %b", ctrl_obs, C_STORE); end
    checks++; if ({out_rs1, out_rs2} !== {5'd2, 5'd3}) begin errors++; $display("FAIL sw_regs: got %0d/%0d want 2/3", out_rs1, out_rs2); end
    issue(enc_b(13'h1FF8, 5'd2, 5'd1, 3'b000), 64'h304);
    tick();
    in_valid = 1'b0;
    checks++; if (out_imm !== 64'hFFFF_FFFF_FFFF_FFF8) begin errors++; $display("FAIL beq_imm: got %h want fffffffffffffff8", out_imm); end
    checks++; if (ctrl_obs !== C_BRANCH) begin errors++; $display("FAIL beq_ctrl: got %b want %b", ctrl_obs, C_BRANCH); end
    checks++; if (out_pc !== 64'h304) begin errors++; $display("FAIL beq_pc: got %h want 304", out_pc); end
    tick();
  endtask

  task automatic test_backpressure();
    issue(enc_r(7'h00, 5'd3, 5'd2, 3'b000, 5'd1, 7'b0110011), 64'h400);
    tick();
    out_ready = 1'b0;
    issue(enc_i(12'd7, 5'd5, 3'b000, 5'd4, 7'b0010011), 64'h404);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); end
      tick();
      checks++; if ({out_valid, out_pc, out_rd} !== {1'b1, 64'h400, 5'd1}) begin errors++;
        $display("FAIL stall_hold[%0d]: got valid=%b pc=%h rd=%0d want 1/400/1", i, out_valid, out_pc, out_rd); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_pc !== 64'h404) begin errors++; $display("FAIL release_pc: got %h want 404", out_pc); end
    checks++; if (ctrl_obs !== C_ADDI) begin errors++; $display("FAIL addi_ctrl: got %b want %b", ctrl_obs, C_ADDI); end
    checks++; if (out_imm !== 64'd7) begin errors++; $display("FAIL addi_imm: got %h want 7", out_imm); end
    tick();
  endtask

  task automatic test_flush();
    issue(enc_r(7'h00, 5'd3, 5'd2, 3'b000, 5'd1, 7'b0110011), 64'h500);
    tick();
    flush = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 64'h99;
    issue(enc_r(7'h00, 5'd0, 5'd9, 3'b000, 5'd12, 7'b0110011), 64'h504);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    tick();
    flush = 1'b0; wb_en = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    issue(enc_r(7'h00, 5'd0, 5'd9, 3'b000, 5'd12, 7'b0110011), 64'h508);
    tick();
    in_valid = 1'b0;
    checks++; if ({out_valid, out_pc} !== {1'b1, 64'h508}) begin errors++;
      $display("FAIL post_flush_issue: got valid=%b pc=%h want 1/508", out_valid, out_pc); end
    checks++; if (out_rs1_val !== 64'h99) begin errors++; $display("FAIL flush_wb_commit: got %h want 99", out_rs1_val); end
    tick();
  endtask

  task automatic test_x0();
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 64'hFFFF;
    issue(enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd13, 7'b0110011), 64'h600);
    tick();
    wb_en = 1'b0;
    checks++; if ({out_rs1_val, out_rs2_val} !== 128'h0) begin errors++;
      $display("FAIL x0_bypass: got %h/%h want 0/0", out_rs1_val, out_rs2_val); end
    issue(enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd13, 7'b0110011), 64'h604);
    tick();
    in_valid = 1'b0;
    checks++; if (out_rs1_val !== 64'h0) begin errors++; $display("FAIL x0_read: got %h want 0", out_rs1_val); end
    tick();
  endtask

  task automatic test_illegal();
    issue(32'h0000_007F, 64'h700);
    tick();
    checks++; if ({out_valid, ctrl_obs} !== {1'b1, C_ILL}) begin errors++;
      $display("FAIL illegal_opcode: got valid=%b ctrl=%b want 1/%b", out_valid, ctrl_obs, C_ILL); end
    issue(enc_r(7'h00, 5'd3, 5'd2, 3'b010, 5'd1, 7'b0110011), 64'h704);
    tick();
    in_valid = 1'b0;
    checks++; if (ctrl_obs !== C_ILL) begin errors++; $display("FAIL illegal_funct3: got %b want %b", ctrl_obs, C_ILL); end
    tick();
  endtask

  task automatic test_shift();
    logic [10:0] exp_sll, exp_srai;
    logic [63:0] exp_imm;
`ifdef DECODE_SHIFT_EN
    exp_sll  = 11'b0100000_0011;
    exp_srai = 11'b1100000_0101;
    exp_imm  = 64'd5;
`else
    exp_sll  = C_ILL;
    exp_srai = C_ILL;
    exp_imm  = 64'd0;
`endif
    issue(enc_r(7'h00, 5'd3, 5'd2, 3'b001, 5'd1, 7'b0110011), 64'h800);
    tick();
    checks++; if ({out_valid, ctrl_obs} !== {1'b1, exp_sll}) begin errors++;
      $display("FAIL sll: got valid=%b ctrl=%b want 1/%b", out_valid, ctrl_obs, exp_sll); end
    issue(enc_i({6'b010000, 6'd5}, 5'd2, 3'b101, 5'd1, 7'b0010011), 64'h804);
    tick();
    in_valid = 1'b0;
    checks++; if (ctrl_obs !== exp_srai) begin errors++; $display("FAIL srai_ctrl: got %b want %b", ctrl_obs, exp_srai); end
    checks++; if (out_imm !== exp_imm) begin errors++; $display("FAIL srai_imm: got %h want %h", out_imm, exp_imm); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_load_use();
    test_store_branch();
    test_backpressure();
    test_flush();
    test_x0();
    test_illegal();
    test_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
